// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one 8-bit PSRAM controller between video, CPU and DMA.
// Port 0 has fixed priority; ports 1/2 round-robin; cs-high gap and timeout guard.
`timescale 1ns/1ps

module psram_arbiter #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clkRAM,
    input  logic        reset,
    input  logic [2:0]  i_req,
    input  logic [2:0]  i_write,
    input  logic [23:0] i_addr0,
    input  logic [23:0] i_addr1,
    input  logic [23:0] i_addr2,
    input  logic [2:0]  i_bank,
    input  logic [7:0]  i_wdata0,
    input  logic [7:0]  i_wdata1,
    input  logic [7:0]  i_wdata2,
    output logic [2:0]  o_ack,
    output logic        o_err,
    output logic [7:0]  o_rdata,
    output logic        o_ready,
    output logic        o_timeout,
    output logic        o_mc_cs,
    output logic        o_mc_write,
    output logic        o_mc_bank,
    output logic [23:0] o_mc_address,
    output logic [7:0]  o_mc_data,
    input  logic [7:0]  i_mc_data,
    input  logic        i_mc_busy,
    input  logic        i_mc_dataReady
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_RELEASE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic          rr_fav2, rr_fav2_n;
    logic [1:0]    grant, grant_n;

    logic [2:0]    ack_n;
    logic          err_n;
    logic [7:0]    rdata_n;
    logic          ready_n;
    logic          timeout_n;
    logic          cs_n;
    logic          write_n;
    logic          bank_n;
    logic [23:0]   addr_n;
    logic [7:0]    data_n;

    logic          win_vld;
    logic [1:0]    win;
    logic          win_write;
    logic          win_bank;
    logic [23:0]   win_addr;
    logic [7:0]    win_data;

    // dataReady is informational only: a read is acked on busy falling
    // whatever its level, so it does not steer any logic here.
    logic unused_inputs;
    assign unused_inputs = i_mc_dataReady;

    // Arbitration: port 0 first, then whichever of 1/2 the pointer favours.
    always_comb begin
        win     = 2'd0;
        win_vld = 1'b1;
        if (i_req[0]) begin
            win = 2'd0;
        end else if (i_req[1] && i_req[2]) begin
            win = rr_fav2 ? 2'd2 : 2'd1;
        end else if (i_req[1]) begin
            win = 2'd1;
        end else if (i_req[2]) begin
            win = 2'd2;
        end else begin
            win_vld = 1'b0;
        end
    end

    // Select the command fields of the winning port.
    always_comb begin
        win_write = i_write[2];
        win_bank  = i_bank[2];
        win_addr  = i_addr2;
        win_data  = i_wdata2;
        unique case (win)
            2'd0: begin
                win_write = i_write[0];
                win_bank  = i_bank[0];
                win_addr  = i_addr0;
                win_data  = i_wdata0;
            end
            2'd1: begin
                win_write = i_write[1];
                win_bank  = i_bank[1];
                win_addr  = i_addr1;
                win_data  = i_wdata1;
            end
            default: begin
                win_write = i_write[2];
                win_bank  = i_bank[2];
                win_addr  = i_addr2;
                win_data  = i_wdata2;
            end
        endcase
    end

    // Next-state and next-output logic for the command sequencer.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        gcnt_n    = gcnt;
        rr_fav2_n = rr_fav2;
        grant_n   = grant;
        ack_n     = 3'b000;
        err_n     = 1'b0;
        rdata_n   = o_rdata;
        ready_n   = o_ready;
        timeout_n = o_timeout;
        cs_n      = o_mc_cs;
        write_n   = o_mc_write;
        bank_n    = o_mc_bank;
        addr_n    = o_mc_address;
        data_n    = o_mc_data;

        unique case (state)
            ST_STARTUP: begin
                if (!i_mc_busy) begin
                    state_n = ST_IDLE;
                    ready_n = 1'b1;
                end
            end
            ST_IDLE: begin
                cnt_n = '0;
                if (win_vld) begin
                    grant_n = win;
                    write_n = win_write;
                    bank_n  = win_bank;
                    addr_n  = win_addr;
                    data_n  = win_data;
                    cs_n    = 1'b0;
                    state_n = ST_ISSUE;
                    if (win != 2'd0) begin
                        rr_fav2_n = ~rr_fav2;
                    end
                end
            end
            ST_ISSUE, ST_WAIT_DONE: begin
                if (cnt == TO_LAST) begin
                    cs_n      = 1'b1;
                    ack_n     = 3'b001 << grant;
                    err_n     = 1'b1;
                    timeout_n = 1'b1;
                    rdata_n   = 8'h00;
                    gcnt_n    = '0;
                    state_n   = ST_RELEASE;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (state == ST_ISSUE) begin
                        if (i_mc_busy) begin
                            cs_n    = 1'b1;
                            state_n = ST_WAIT_DONE;
                        end
                    end else if (!i_mc_busy) begin
                        ack_n   = 3'b001 << grant;
                        gcnt_n  = '0;
                        state_n = ST_RELEASE;
                        if (!o_mc_write) begin
                            rdata_n = i_mc_data;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                if (gcnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_STARTUP;
                cs_n    = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clkRAM or posedge reset) begin
        if (reset) begin
            state        <= ST_STARTUP;
            cnt          <= '0;
            gcnt         <= '0;
            rr_fav2      <= 1'b0;
            grant        <= 2'd0;
            o_ack        <= 3'b000;
            o_err        <= 1'b0;
            o_rdata      <= 8'h00;
            o_ready      <= 1'b0;
            o_timeout    <= 1'b0;
            o_mc_cs      <= 1'b1;
            o_mc_write   <= 1'b0;
            o_mc_bank    <= 1'b0;
            o_mc_address <= 24'h000000;
            o_mc_data    <= 8'h00;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            gcnt         <= gcnt_n;
            rr_fav2      <= rr_fav2_n;
            grant        <= grant_n;
            o_ack        <= ack_n;
            o_err        <= err_n;
            o_rdata      <= rdata_n;
            o_ready      <= ready_n;
            o_timeout    <= timeout_n;
            o_mc_cs      <= cs_n;
            o_mc_write   <= write_n;
            o_mc_bank    <= bank_n;
            o_mc_address <= addr_n;
            o_mc_data    <= data_n;
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: vector table, directed corner sequences and a random
// phase checked against a request-level arbitration/memory model.
`timescale 1ns/1ps

module tb_psram_arbiter;

    localparam int GAP = 2;
    localparam int TMO = 255;

    logic        i_clkRAM = 1'b0;
    logic        reset    = 1'b1;
    logic [2:0]  i_req    = 3'b000;
    logic [2:0]  i_write  = 3'b000;
    logic [2:0]  i_bank   = 3'b000;
    logic [23:0] addr [3];
    logic [7:0]  wdata [3];
    logic [2:0]  o_ack;
    logic        o_err;
    logic [7:0]  o_rdata;
    logic        o_ready;
    logic        o_timeout;
    logic        o_mc_cs;
    logic        o_mc_write;
    logic        o_mc_bank;
    logic [23:0] o_mc_address;
    logic [7:0]  o_mc_data;
    logic [7:0]  i_mc_data      = 8'h00;
    logic        i_mc_busy      = 1'b1;
    logic        i_mc_dataReady = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    bit init_busy = 1'b1;
    bit stuck     = 1'b0;
    bit long_lat  = 1'b0;

    psram_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clkRAM       (i_clkRAM),
        .reset          (reset),
        .i_req          (i_req),
        .i_write        (i_write),
        .i_addr0        (addr[0]),
        .i_addr1        (addr[1]),
        .i_addr2        (addr[2]),
        .i_bank         (i_bank),
        .i_wdata0       (wdata[0]),
        .i_wdata1       (wdata[1]),
        .i_wdata2       (wdata[2]),
        .o_ack          (o_ack),
        .o_err          (o_err),
        .o_rdata        (o_rdata),
        .o_ready        (o_ready),
        .o_timeout      (o_timeout),
        .o_mc_cs        (o_mc_cs),
        .o_mc_write     (o_mc_write),
        .o_mc_bank      (o_mc_bank),
        .o_mc_address   (o_mc_address),
        .o_mc_data      (o_mc_data),
        .i_mc_data      (i_mc_data),
        .i_mc_busy      (i_mc_busy),
        .i_mc_dataReady (i_mc_dataReady)
    );

    always #5 i_clkRAM = ~i_clkRAM;

    // Unwritten PSRAM locations read back as a fixed function of the key.
    function automatic logic [7:0] dflt(input logic [24:0] k);
        return k[7:0] ^ 8'h2C;
    endfunction

    // Controller model: busy during init, then one op per falling cs edge.
    logic [7:0]  cm_mem [logic [24:0]];
    int          busy_cnt = 0;
    bit          cm_prev_cs = 1'b1;
    logic        cm_w;
    logic [24:0] cm_key;
    logic [7:0]  cm_wd;
    always @(negedge i_clkRAM) begin
        if (reset) begin
            busy_cnt       = 0;
            cm_prev_cs     = 1'b1;
            i_mc_busy      = init_busy;
            i_mc_dataReady = 1'b0;
        end else if (init_busy) begin
            i_mc_busy  = 1'b1;
            cm_prev_cs = o_mc_cs;
        end else begin
            if (busy_cnt != 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    if (cm_w) begin
                        cm_mem[cm_key] = cm_wd;
                    end else begin
                        i_mc_data = cm_mem.exists(cm_key) ? cm_mem[cm_key] : dflt(cm_key);
                        i_mc_dataReady = 1'b1;
                    end
                    i_mc_busy = 1'b0;
                end
            end else if (!stuck && cm_prev_cs && !o_mc_cs) begin
                i_mc_busy      = 1'b1;
                i_mc_dataReady = 1'b0;
                busy_cnt       = long_lat ? 30 : $urandom_range(1, 4);
                cm_w           = o_mc_write;
                cm_key         = {o_mc_bank, o_mc_address};
                cm_wd          = o_mc_data;
            end else begin
                i_mc_busy = 1'b0;
            end
            cm_prev_cs = o_mc_cs;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          port;
        logic        write;
        logic [23:0] addr;
        logic        bank;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clkRAM);
        #1;
    endtask

    task automatic set_port(input vec_t v);
        addr[v.port]    = v.addr;
        wdata[v.port]   = v.wdata;
        i_write[v.port] = v.write;
        i_bank[v.port]  = v.bank;
        i_req[v.port]   = 1'b1;
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (o_ack == 3'b000 && cyc < 600);
    endtask

    task automatic do_txn(input string name, input vec_t v);
        int cyc;
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        set_port(v);
        do begin
            tick();
            cyc++;
            if (!o_mc_cs && !seen) begin
                seen = 1'b1;
                chk({name, "_issue"},
                    {o_mc_write, o_mc_bank, o_mc_address, o_mc_data},
                    {v.write, v.bank, v.addr, v.wdata});
            end
        end while (o_ack == 3'b000 && cyc < 600);
        chk({name, "_ack"}, {o_ack, o_err}, {3'b001 << v.port, 1'b0});
        if (!v.write) begin
            chk({name, "_rdata"}, o_rdata, v.rdata);
        end
        i_req[v.port] = 1'b0;
        tick();
        chk({name, "_pulse"}, o_ack, 3'b000);
    endtask

    task automatic reset_and_init();
        int cyc;
        i_req     = 3'b000;
        init_busy = 1'b1;
        reset     = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        init_busy = 1'b0;
        cyc = 0;
        while (!o_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("init_ready", o_ready, 1'b1);
    endtask

    vec_t        tbl [10];
    int          order [7];
    logic [7:0]  ref_mem [logic [24:0]];

    initial begin
        int cyc;
        int acks;
        int readies;
        vec_t v;

        tbl[0] = '{1, 1'b1, 24'h012345, 1'b1, 8'hA5, 8'h00};
        tbl[1] = '{0, 1'b0, 24'h000010, 1'b0, 8'h00, 8'h3C};
        tbl[2] = '{2, 1'b1, 24'h000100, 1'b0, 8'h11, 8'h00};
        tbl[3] = '{1, 1'b1, 24'h000100, 1'b1, 8'h22, 8'h00};
        tbl[4] = '{0, 1'b0, 24'h000100, 1'b0, 8'h00, 8'h11};
        tbl[5] = '{2, 1'b0, 24'h000100, 1'b1, 8'h00, 8'h22};
        tbl[6] = '{1, 1'b0, 24'h012345, 1'b1, 8'h00, 8'hA5};
        tbl[7] = '{2, 1'b0, 24'h0000FF, 1'b0, 8'h00, 8'hD3};
        tbl[8] = '{0, 1'b1, 24'hFFFFFF, 1'b1, 8'h5A, 8'h00};
        tbl[9] = '{1, 1'b0, 24'hFFFFFF, 1'b1, 8'h00, 8'h5A};
        order  = '{0, 0, 0, 1, 2, 1, 2};
        for (int p = 0; p < 3; p++) begin
            addr[p]  = 24'h0;
            wdata[p] = 8'h0;
        end

        // Reset values and a long controller init.
        repeat (3) tick();
        chk("rst_outs",
            {o_ack, o_err, o_rdata, o_ready, o_timeout, o_mc_cs,
             o_mc_write, o_mc_bank, o_mc_address, o_mc_data},
            {3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 8'h00});
        reset   = 1'b0;
        acks    = 0;
        readies = 0;
        for (int i = 0; i < 15000; i++) begin
            tick();
            if (i == 10) begin
                v = '{1, 1'b1, 24'h00ABCD, 1'b0, 8'h66, 8'h00};
                set_port(v);
            end
            if (o_ack != 3'b000) acks++;
            if (o_ready) readies++;
        end
        chk("startup_no_ack", 64'(acks), 64'd0);
        chk("startup_not_ready", 64'(readies), 64'd0);
        init_busy = 1'b0;
        tick();
        chk("startup_busy_fell", i_mc_busy, 1'b0);
        chk("startup_ready_lag", o_ready, 1'b0);
        tick();
        chk("startup_ready_rise", o_ready, 1'b1);
        wait_ack(cyc);
        chk("startup_served", {o_ack, o_err}, {3'b010, 1'b0});
        i_req = 3'b000;
        tick();

        // Vector table: one transaction per record.
        for (int i = 0; i < 10; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i]);
            repeat (2) tick();
        end

        // Request held through its ack is reissued after the cs-high gap.
        v = '{1, 1'b1, 24'h000300, 1'b0, 8'h31, 8'h00};
        set_port(v);
        wait_ack(cyc);
        chk("b2b_ack1", o_ack, 3'b010);
        cyc = 0;
        while (o_mc_cs && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("b2b_cs_high", 64'(cyc - 1), 64'(GAP));
        wait_ack(cyc);
        chk("b2b_ack2", o_ack, 3'b010);
        i_req = 3'b000;
        repeat (4) tick();

        // Controller never raises busy: abort with err after the timeout.
        stuck = 1'b1;
        v = '{2, 1'b1, 24'h000500, 1'b0, 8'h77, 8'h00};
        set_port(v);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (o_mc_cs && cyc < 50);
        chk("to_cs_low", o_mc_cs, 1'b0);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (o_ack == 3'b000 && cyc < TMO + 50);
        chk("to_latency", 64'(cyc), 64'(TMO));
        chk("to_ack_err", {o_ack, o_err, o_timeout, o_rdata},
            {3'b100, 1'b1, 1'b1, 8'h00});
        i_req = 3'b000;
        stuck = 1'b0;
        tick();
        chk("to_err_pulse", {o_ack, o_err}, 4'b0000);
        repeat (5) tick();
        chk("to_sticky", o_timeout, 1'b1);
        v = '{1, 1'b0, 24'h012345, 1'b1, 8'h00, 8'hA5};
        do_txn("to_recover", v);
        chk("to_sticky2", o_timeout, 1'b1);

        // Contention: all three held, then port 0 withdrawn.
        reset_and_init();
        chk("ctn_to_clear", o_timeout, 1'b0);
        for (int p = 0; p < 3; p++) begin
            v = '{p, 1'b1, 24'h000400 + 24'(p), 1'b0, 8'(8'h40 + p), 8'h00};
            set_port(v);
        end
        for (int i = 0; i < 7; i++) begin
            wait_ack(cyc);
            chk($sformatf("ctn_grant%0d", i), o_ack, 3'b001 << order[i]);
            if (i == 2) i_req[0] = 1'b0;
        end
        i_req = 3'b000;
        repeat (6) tick();

        // Reset while the controller is still busy with a read.
        long_lat = 1'b1;
        v = '{0, 1'b0, 24'h000010, 1'b0, 8'h00, 8'h3C};
        set_port(v);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (o_mc_cs && cyc < 50);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!o_mc_cs && cyc < 50);
        repeat (3) tick();
        chk("midop_waiting", {o_mc_cs, i_mc_busy, o_ack}, {1'b1, 1'b1, 3'b000});
        #1;
        init_busy = 1'b1;
        reset     = 1'b1;
        #1;
        chk("midop_rst", {o_mc_cs, o_ack, o_ready}, {1'b1, 3'b000, 1'b0});
        long_lat = 1'b0;
        reset_and_init();
        do_txn("midop_recover", v);

        // Random traffic against the request-level reference model.
        reset_and_init();
        begin
            logic [2:0] req_prev;
            bit         prev_cs;
            bit         outstanding;
            int         fav;
            int         e;
            int         just;
            int         done;
            int         t;
            logic [24:0] key;
            req_prev    = 3'b000;
            prev_cs     = 1'b1;
            outstanding = 1'b0;
            fav         = 1;
            e           = 0;
            done        = 0;
            t           = 0;
            while (done < 150 && t < 15000) begin
                tick();
                t++;
                just = -1;
                if (prev_cs && !o_mc_cs) begin
                    if (req_prev[0]) e = 0;
                    else if (req_prev[1] && req_prev[2]) e = fav;
                    else if (req_prev[1]) e = 1;
                    else if (req_prev[2]) e = 2;
                    else e = -1;
                    chk("rand_issue_valid", 64'(e >= 0), 64'd1);
                    if (e < 0) e = 0;
                    if (e != 0) fav = (fav == 1) ? 2 : 1;
                    chk("rand_issue",
                        {o_mc_write, o_mc_bank, o_mc_address, o_mc_data},
                        {i_write[e], i_bank[e], addr[e], wdata[e]});
                    outstanding = 1'b1;
                end
                if (o_ack != 3'b000) begin
                    chk("rand_ack", {outstanding, o_ack, o_err},
                        {1'b1, 3'b001 << e, 1'b0});
                    key = {i_bank[e], addr[e]};
                    if (!i_write[e]) begin
                        chk("rand_rdata", o_rdata,
                            ref_mem.exists(key) ? ref_mem[key] : dflt(key));
                    end else begin
                        ref_mem[key] = wdata[e];
                    end
                    i_req[e]    = 1'b0;
                    just        = e;
                    outstanding = 1'b0;
                    done++;
                end
                for (int p = 0; p < 3; p++) begin
                    if (!i_req[p] && p != just &&
                        $urandom_range(0, (p == 0) ? 15 : 5) == 0) begin
                        i_write[p] = 1'($urandom_range(0, 1));
                        i_bank[p]  = 1'($urandom_range(0, 1));
                        addr[p]    = 24'h000200 | 24'($urandom_range(0, 7));
                        wdata[p]   = 8'($urandom_range(0, 255));
                        i_req[p]   = 1'b1;
                    end
                end
                req_prev = i_req;
                prev_cs  = o_mc_cs;
            end
            chk("rand_done", 64'(done), 64'd150);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the single 8-bit PSRAM controller between three requesters:
  - port 0: video fetch, fixed highest priority;
  - ports 1 and 2: CPU and DMA/loader, round-robin between themselves.
- Converts per-port req/ack handshakes into the controller's command sequence: active-low cs edge, busy/dataReady completion.
- Enforces the inter-command cs-high gap the controller needs to re-arm its edge detector.
- Flags stuck transactions with a timeout.

Parameters:
- GAP_CYCLES, 2, minimum cycles o_mc_cs is held high in RELEASE before the next issue (must be >=2).
- TIMEOUT_CYCLES, 255, maximum cycles allowed from ISSUE until completion before abort.

Ports:
- i_clkRAM  input  1  RAM clock (100 MHz), same clock as the controller
- reset  input  1  asynchronous, active-high reset
- i_req[2:0]  input  3  per-port request; hold with fields stable until that port's ack
- i_write[2:0]  input  3  per-port 1=write, 0=read
- i_addr0, i_addr1, i_addr2  input  24 each  per-port byte address
- i_bank[2:0]  input  3  per-port bank select (0=U7, 1=U9)
- i_wdata0, i_wdata1, i_wdata2  input  8 each  per-port write data
- o_ack[2:0]  output  3  one-cycle completion pulse per port
- o_err  output  1  pulses together with o_ack when the transaction timed out
- o_rdata  output  8  read data, valid in the o_ack cycle of a read
- o_ready  output  1  1 once the controller has finished power-up init
- o_timeout  output  1  sticky; set on any timeout, cleared only by reset
- o_mc_cs  output  1  to controller i_cs (0 = request)
- o_mc_write, o_mc_bank  output  1 each  to controller i_write, i_bank
- o_mc_address  output  24  to controller i_address
- o_mc_data  output  8  to controller i_dataToWrite
- i_mc_data  input  8  from controller o_dataRead
- i_mc_busy  input  1  from controller o_busy
- i_mc_dataReady  input  1  from controller o_dataReady

Behaviour:
- Reset values (asynchronous, active-high):
  - state STARTUP; o_mc_cs=1; all other outputs 0.
  - round-robin pointer = port 1 next; counters 0.
  - Reset mid-transaction aborts with no ack; requesters must re-request.
- STARTUP: stay until i_mc_busy=0 is sampled. Then go to IDLE and set o_ready=1; o_ready stays 1 until reset. Requests are ignored (no ack) while o_ready=0.
- IDLE, arbitration on each edge:
  - req[0] wins if set.
  - Otherwise, of req[1]/req[2] the one the pointer favours wins, else the other.
  - Pointer toggles only when port 1 or 2 is granted.
  - Winner's write/addr/bank/wdata are latched onto the o_mc_* outputs; o_mc_cs<=0; go to ISSUE.
  - Simultaneous requests resolve the same edge; losers wait, and their req stays pending.
- ISSUE: hold o_mc_cs=0 until i_mc_busy=1 is sampled. Then o_mc_cs<=1 and go to WAIT_DONE.
- WAIT_DONE: on sampling i_mc_busy=0, complete:
  - pulse o_ack[grant] for one cycle;
  - if read, o_rdata<=i_mc_data (i_mc_dataReady is expected 1; if it is 0, still ack, o_rdata=i_mc_data);
  - go to RELEASE.
- RELEASE: o_mc_cs=1 for GAP_CYCLES cycles, then IDLE.
- Back-to-back requests: a req still high after its ack is treated as a new request. Minimum issue-to-issue spacing is GAP_CYCLES+3 cycles plus controller latency.
- Timeout:
  - Cycle counter runs from entry to ISSUE and is cleared in IDLE.
  - When it reaches TIMEOUT_CYCLES in ISSUE or WAIT_DONE: o_mc_cs<=1, pulse o_ack[grant] together with o_err, set o_timeout, o_rdata=0, go to RELEASE.
- Fairness: ports 1/2 are never starved by each other. Port 0 may starve them; this is intentional, since video bandwidth is bounded by the system.
- o_mc_* fields stay stable from ISSUE through WAIT_DONE and hold their last value otherwise.
- Counter widths must be sized to hold TIMEOUT_CYCLES and GAP_CYCLES.

Test Plan:
- Startup: release reset with i_mc_busy=1 for 15000 cycles, then 0 -> o_ready rises 1 cycle after busy falls; a req[1] raised earlier gets no ack before o_ready, then is served.
- Single write: port 1 writes 0xA5 to 0x012345, bank 1 -> o_mc_cs low until busy seen, with o_mc_address=0x012345, o_mc_bank=1, o_mc_write=1, o_mc_data=0xA5; exactly one o_ack[1] pulse; o_mc_cs high for >=2 cycles afterwards.
- Read: port 0 reads 0x000010 with controller model returning 0x3C -> o_ack[0] with o_rdata=0x3C, o_err=0.
- Contention: req[2:0]=3'b111 held continuously -> grant order 0,0,0,... while req[0] is held; drop req[0] -> order 1,2,1,2 alternating.
- Timeout: i_mc_busy stuck at 0 after cs falls -> after 255 cycles, o_ack[grant] and o_err pulse together, o_timeout=1 and remains 1; the next request is still served normally.
- Reset mid-op: assert reset during WAIT_DONE -> o_mc_cs=1, o_ack=0, o_ready=0 immediately; normal operation resumes after startup.
